// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-clock controller.
package alarm_pkg;

    localparam int unsigned HW       = 5;
    localparam int unsigned MW       = 6;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_TH = 3'd1,
        SET_TM = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_RING   = 2'd1,
        R_SNOOZE = 2'd2
    } ring_e;

    // Set-mode sequence followed on each btn_mode press.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            RUN:     return SET_TH;
            SET_TH:  return SET_TM;
            SET_TM:  return SET_AH;
            SET_AH:  return SET_AM;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/alarm_sched_if.sv
// Button/tick inputs and time/alarm/buzzer outputs of the alarm controller.
interface alarm_sched_if;
    import alarm_pkg::*;

    logic          tick_sec;
    logic          alarm_en;
    logic          btn_mode;
    logic          btn_inc;
    logic          btn_snooze;
    logic          btn_stop;
    logic [HW-1:0] hour;
    logic [MW-1:0] minute;
    logic [MW-1:0] second;
    logic [HW-1:0] al_hour;
    logic [MW-1:0] al_min;
    mode_e         mode;
    logic          ring;
    logic          snoozing;

    // Driver side: seconds counter and button debouncers.
    modport master (
        output tick_sec, alarm_en, btn_mode, btn_inc, btn_snooze, btn_stop,
        input  hour, minute, second, al_hour, al_min, mode, ring, snoozing
    );

    // Controller side.
    modport slave (
        input  tick_sec, alarm_en, btn_mode, btn_inc, btn_snooze, btn_stop,
        output hour, minute, second, al_hour, al_min, mode, ring, snoozing
    );
endinterface

// File: rtl/alarm_sched_wrap_cntr.sv
// Modulo-(MAX+1) counter with clear/load and a same-cycle carry for chaining.
module wrap_cntr #(
    parameter int unsigned MAX     = 59,
    parameter int unsigned W       = 6,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_q,
    output logic         o_carry_c
);

    localparam logic [W-1:0] L_MAX = W'(MAX);
    localparam logic [W-1:0] L_RST = W'(RST_VAL);

    logic [W-1:0] r_q;

    assign o_q       = r_q;
    assign o_carry_c = i_inc && !i_clr && !i_load && (r_q == L_MAX);

    // Clear beats load beats increment; increment wraps MAX -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= L_RST;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_val;
        end else if (i_inc) begin
            r_q <= (r_q == L_MAX) ? '0 : r_q + W'(1);
        end
    end

endmodule

// File: rtl/alarm_sched.sv
// Alarm-clock controller: time of day, set modes, alarm trigger, ring/snooze.
module alarm_sched
    import alarm_pkg::*;
#(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned ALARM_RST_H    = 7,
    parameter int unsigned ALARM_RST_M    = 0
) (
    input  logic          clk,
    input  logic          rst,
    alarm_sched_if.slave  bus
);

    localparam int unsigned TMAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RING_LD = TW'(RING_TIMEOUT_S);
    localparam logic [TW-1:0] SNZ_LD  = TW'(SNOOZE_S);

    mode_e         r_mode, w_mode_nxt;
    ring_e         r_ring_st, w_ring_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_ring, r_snoozing, r_adv;

    logic          w_inc, w_time_run, w_tick, w_clr_sec;
    logic          w_sec_carry, w_min_carry;
    logic          w_unused_hr_carry, w_unused_ah_carry, w_unused_am_carry;
    logic          w_match, w_trig, w_kill;
    logic [HW-1:0] w_hour, w_al_hour;
    logic [MW-1:0] w_minute, w_second, w_al_min;

    // A simultaneous mode press swallows the increment.
    assign w_inc      = bus.btn_inc && !bus.btn_mode;
    assign w_time_run = (r_mode == RUN) || (r_mode == SET_AH) || (r_mode == SET_AM);
    assign w_tick     = bus.tick_sec && w_time_run;
    assign w_clr_sec  = (w_mode_nxt == SET_TH) && (r_mode != SET_TH);

    wrap_cntr #(.MAX(MIN_MAX), .W(MW), .RST_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .i_inc(w_tick), .i_clr(w_clr_sec),
        .i_load(1'b0), .i_val('0), .o_q(w_second), .o_carry_c(w_sec_carry)
    );

    wrap_cntr #(.MAX(MIN_MAX), .W(MW), .RST_VAL(0)) u_min (
        .clk(clk), .rst(rst), .i_inc(w_sec_carry || (w_inc && (r_mode == SET_TM))),
        .i_clr(1'b0), .i_load(1'b0), .i_val('0), .o_q(w_minute), .o_carry_c(w_min_carry)
    );

    wrap_cntr #(.MAX(HOUR_MAX), .W(HW), .RST_VAL(0)) u_hour (
        .clk(clk), .rst(rst), .i_inc(w_min_carry || (w_inc && (r_mode == SET_TH))),
        .i_clr(1'b0), .i_load(1'b0), .i_val('0), .o_q(w_hour), .o_carry_c(w_unused_hr_carry)
    );

    wrap_cntr #(.MAX(HOUR_MAX), .W(HW), .RST_VAL(ALARM_RST_H)) u_al_hour (
        .clk(clk), .rst(rst), .i_inc(w_inc && (r_mode == SET_AH)),
        .i_clr(1'b0), .i_load(1'b0), .i_val('0), .o_q(w_al_hour), .o_carry_c(w_unused_ah_carry)
    );

    wrap_cntr #(.MAX(MIN_MAX), .W(MW), .RST_VAL(ALARM_RST_M)) u_al_min (
        .clk(clk), .rst(rst), .i_inc(w_inc && (r_mode == SET_AM)),
        .i_clr(1'b0), .i_load(1'b0), .i_val('0), .o_q(w_al_min), .o_carry_c(w_unused_am_carry)
    );

    // Fire only on the second the clock has just ticked into, so a match fires once.
    assign w_match = (w_hour == w_al_hour) && (w_minute == w_al_min) && (w_second == '0);
    assign w_trig  = r_adv && w_match && (r_mode == RUN) && bus.alarm_en && (r_ring_st == R_IDLE);
    assign w_kill  = !bus.alarm_en || (w_mode_nxt != RUN);

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Mode next-state.
    always_comb begin
        w_mode_nxt = r_mode;
        if (bus.btn_mode) begin
            w_mode_nxt = next_mode(r_mode);
        end
    end

    // Ring state, timer, registered buzzer outputs and tick-advance flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ring_st  <= R_IDLE;
            r_timer    <= '0;
            r_ring     <= 1'b0;
            r_snoozing <= 1'b0;
            r_adv      <= 1'b0;
        end else begin
            r_ring_st  <= w_ring_nxt;
            r_timer    <= w_timer_nxt;
            r_ring     <= (w_ring_nxt == R_RING);
            r_snoozing <= (w_ring_nxt == R_SNOOZE);
            r_adv      <= w_tick;
        end
    end

    // Ring next-state: stop > snooze > expiry; disarm or leaving RUN overrides all.
    always_comb begin
        w_ring_nxt  = r_ring_st;
        w_timer_nxt = r_timer;
        case (r_ring_st)
            R_IDLE: begin
                if (w_trig) begin
                    w_ring_nxt  = R_RING;
                    w_timer_nxt = RING_LD;
                end
            end
            R_RING: begin
                if (bus.btn_stop) begin
                    w_ring_nxt  = R_IDLE;
                    w_timer_nxt = '0;
                end else if (bus.btn_snooze) begin
                    w_ring_nxt  = R_SNOOZE;
                    w_timer_nxt = SNZ_LD;
                end else if (bus.tick_sec) begin
                    if (r_timer <= TW'(1)) begin
                        w_ring_nxt  = R_IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
            end
            R_SNOOZE: begin
                if (bus.btn_stop) begin
                    w_ring_nxt  = R_IDLE;
                    w_timer_nxt = '0;
                end else if (bus.tick_sec) begin
                    if (r_timer <= TW'(1)) begin
                        w_ring_nxt  = R_RING;
                        w_timer_nxt = RING_LD;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
            end
            default: begin
                w_ring_nxt  = R_IDLE;
                w_timer_nxt = '0;
            end
        endcase
        if (w_kill) begin
            w_ring_nxt  = R_IDLE;
            w_timer_nxt = '0;
        end
    end

    assign bus.hour     = w_hour;
    assign bus.minute   = w_minute;
    assign bus.second   = w_second;
    assign bus.al_hour  = w_al_hour;
    assign bus.al_min   = w_al_min;
    assign bus.mode     = r_mode;
    assign bus.ring     = r_ring;
    assign bus.snoozing = r_snoozing;

endmodule

// File: tb/tb_alarm_sched.sv
// Directed bench for alarm_sched: vector table plus hand-written ring/snooze/reset sequences.
module tb_alarm_sched;
    import alarm_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alarm_sched_if bus();

    alarm_sched #(
        .RING_TIMEOUT_S(5),
        .SNOOZE_S      (3),
        .ALARM_RST_H   (7),
        .ALARM_RST_M   (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int t; int md; int in; int sz; int sp;
        int h; int m; int s; int ah; int am; int mo; int rg; int sn;
    } vec_t;

    vec_t tbl[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int h, input int m, input int s,
                               input int ah, input int am, input int mo,
                               input int rg, input int sn);
        check({tag, " hour"},     int'(bus.hour),     h);
        check({tag, " minute"},   int'(bus.minute),   m);
        check({tag, " second"},   int'(bus.second),   s);
        check({tag, " al_hour"},  int'(bus.al_hour),  ah);
        check({tag, " al_min"},   int'(bus.al_min),   am);
        check({tag, " mode"},     int'(bus.mode),     mo);
        check({tag, " ring"},     int'(bus.ring),     rg);
        check({tag, " snoozing"}, int'(bus.snoozing), sn);
    endtask

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic step(input int t, input int md, input int in, input int sz, input int sp);
        @(negedge clk);
        bus.tick_sec   = (t  != 0);
        bus.btn_mode   = (md != 0);
        bus.btn_inc    = (in != 0);
        bus.btn_snooze = (sz != 0);
        bus.btn_stop   = (sp != 0);
        @(posedge clk);
        #1;
        bus.tick_sec   = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_snooze = 1'b0;
        bus.btn_stop   = 1'b0;
    endtask

    task automatic tk(input int n);   repeat (n) step(1, 0, 0, 0, 0); endtask
    task automatic inc(input int n);  repeat (n) step(0, 0, 1, 0, 0); endtask
    task automatic md(input int n);   repeat (n) step(0, 1, 0, 0, 0); endtask
    task automatic idle(input int n); repeat (n) step(0, 0, 0, 0, 0); endtask

    // From RUN with time ch:cm, leave RUN with time h:m:00.
    task automatic set_time(input int ch, input int cm, input int h, input int m);
        md(1);
        inc((h - ch + 24) % 24);
        md(1);
        inc((m - cm + 60) % 60);
        md(3);
    endtask

    // From RUN with alarm cah:cam, leave RUN with alarm ah:am (clears seconds).
    task automatic set_alarm(input int cah, input int cam, input int ah, input int am);
        md(3);
        inc((ah - cah + 24) % 24);
        md(1);
        inc((am - cam + 60) % 60);
        md(1);
    endtask

    // From time (ah:am - 1 minute):00 in RUN, run into the alarm and expect ringing.
    task automatic ring_up(input string tag, input int ah, input int am);
        tk(60);
        idle(1);
        check_state(tag, ah, am, 0, ah, am, int'(RUN), 1, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.tick_sec   = 1'b0;
        bus.alarm_en   = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_snooze = 1'b0;
        bus.btn_stop   = 1'b0;

        //           t md in sz sp   h  m  s  ah am mo rg sn
        tbl[0]  = '{0, 0, 1, 0, 0,   1, 1, 0, 7, 0, 2, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0,   1, 1, 0, 7, 0, 2, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0,   1, 1, 0, 7, 0, 3, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 0,   1, 1, 1, 8, 0, 3, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0,   1, 1, 1, 9, 0, 3, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 0,   1, 1, 1, 9, 0, 4, 0, 0};
        tbl[6]  = '{1, 0, 1, 0, 0,   1, 1, 2, 9, 1, 4, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 0,   1, 1, 2, 9, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0,   1, 1, 2, 9, 1, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0,   1, 1, 3, 9, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 1, 1,   1, 1, 3, 9, 1, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0,   1, 1, 0, 9, 1, 1, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0,   1, 1, 0, 9, 1, 2, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0,   1, 1, 0, 9, 1, 3, 0, 0};

        repeat (3) @(negedge clk);
        check_state("reset", 0, 0, 0, 7, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Timekeeping and full-day wrap.
        tk(3661);
        check_state("3661 ticks", 1, 1, 1, 7, 0, 0, 0, 0);
        md(1);
        check_state("enter SET_TH", 1, 1, 0, 7, 0, 1, 0, 0);
        inc(22); md(1); inc(58); md(1);
        check_state("23:59 set", 23, 59, 0, 7, 0, 3, 0, 0);
        tk(59); md(2);
        check_state("23:59:59", 23, 59, 59, 7, 0, 0, 0, 0);
        tk(1);
        check_state("midnight wrap", 0, 0, 0, 7, 0, 0, 0, 0);

        // Hour wrap on increment, frozen clock, mode+inc collision.
        md(1); inc(25);
        check_state("inc x25", 1, 0, 0, 7, 0, 1, 0, 0);
        tk(10);
        check_state("frozen", 1, 0, 0, 7, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check_state("mode+inc", 1, 0, 0, 7, 0, 2, 0, 0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].t, tbl[i].md, tbl[i].in, tbl[i].sz, tbl[i].sp);
            check_state($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s,
                        tbl[i].ah, tbl[i].am, tbl[i].mo, tbl[i].rg, tbl[i].sn);
        end

        // Alarm field wraps back to 07:00.
        inc(22); md(1); inc(59);
        check_state("alarm wrap", 1, 1, 0, 7, 0, 4, 0, 0);
        md(1);

        // Trigger latency and auto-timeout.
        set_time(1, 1, 6, 59);
        @(negedge clk);
        bus.alarm_en = 1'b1;
        tk(58);
        check_state("06:59:58", 6, 59, 58, 7, 0, 0, 0, 0);
        tk(2);
        check_state("07:00:00 pre-ring", 7, 0, 0, 7, 0, 0, 0, 0);
        idle(1);
        check_state("ring rise", 7, 0, 0, 7, 0, 0, 1, 0);
        tk(4);
        check_state("ring 4 ticks", 7, 0, 4, 7, 0, 0, 1, 0);
        tk(1);
        check_state("ring timeout", 7, 0, 5, 7, 0, 0, 0, 0);
        idle(3);
        check_state("no refire", 7, 0, 5, 7, 0, 0, 0, 0);

        // Snooze, ignored re-snooze, re-ring, stop beats snooze.
        set_time(7, 0, 6, 59);
        ring_up("ring2", 7, 0);
        step(0, 0, 0, 1, 0);
        check_state("snooze", 7, 0, 0, 7, 0, 0, 0, 1);
        tk(1);
        step(0, 0, 0, 1, 0);
        check_state("snooze ignored", 7, 0, 1, 7, 0, 0, 0, 1);
        tk(1);
        check_state("snooze 2", 7, 0, 2, 7, 0, 0, 0, 1);
        tk(1);
        check_state("re-ring", 7, 0, 3, 7, 0, 0, 1, 0);
        tk(1);
        check_state("re-ring tick", 7, 0, 4, 7, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        check_state("stop wins", 7, 0, 4, 7, 0, 0, 0, 0);

        // Disarm while ringing.
        set_time(7, 0, 6, 59);
        ring_up("ring3", 7, 0);
        @(negedge clk);
        bus.alarm_en = 1'b0;
        @(posedge clk);
        #1;
        check_state("en off", 7, 0, 0, 7, 0, 0, 0, 0);
        @(negedge clk);
        bus.alarm_en = 1'b1;
        idle(2);
        check_state("no refire after en", 7, 0, 0, 7, 0, 0, 0, 0);

        // Leaving RUN while ringing.
        set_time(7, 0, 6, 59);
        ring_up("ring4", 7, 0);
        md(1);
        check_state("mode kill", 7, 0, 0, 7, 0, 1, 0, 0);
        md(4);

        // Async reset mid-snooze with a non-default alarm.
        set_alarm(7, 0, 12, 34);
        set_time(7, 0, 12, 33);
        ring_up("ring5", 12, 34);
        step(0, 0, 0, 1, 0);
        tk(1);
        check_state("pre-reset snooze", 12, 34, 1, 12, 34, 0, 0, 1);
        #3;
        rst = 1'b1;
        #1;
        check_state("async reset", 0, 0, 0, 7, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        step(1, 0, 1, 0, 0);
        check_state("reset holds", 0, 0, 0, 7, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check_state("post reset", 0, 0, 0, 7, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
